// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core sharing one valid/ready memory port for fetch and data.
// Optional MC_CPU_BRANCH_EXT_EN adds bne/blez/bgtz/bltz; undefined, those opcodes are no-ops.
module mc_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [4:0]  DBG_REG0 = 5'd2,
   parameter logic [4:0]  DBG_REG1 = 5'd4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] output1,
   output logic [31:0] output2
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0,  OP_REGIMM = 6'd1,  OP_J     = 6'd2,  OP_JAL  = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE    = 6'd5,  OP_BLEZ  = 6'd6,  OP_BGTZ = 6'd7;
   localparam logic [5:0] OP_ADDI  = 6'd8,  OP_ADDIU  = 6'd9,  OP_SLTI  = 6'd10, OP_SLTIU = 6'd11;
   localparam logic [5:0] OP_ANDI  = 6'd12, OP_ORI    = 6'd13, OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35, OP_SW     = 6'd43;

   state_t      state, state_nxt;
   logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
   logic [31:0] rf [32];

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] sext_imm, zext_imm;
   logic        is_alu, is_j, is_jal, is_jr, is_jalr, is_br, is_lw, is_sw, legal;
   logic        br_taken;
   logic [31:0] alu_res;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   assign opcode   = ir[31:26];
   assign rs       = ir[25:21];
   assign rt       = ir[20:16];
   assign rd       = ir[15:11];
   assign shamt    = ir[10:6];
   assign funct    = ir[5:0];
   assign sext_imm = {{16{ir[15]}}, ir[15:0]};
   assign zext_imm = {16'h0000, ir[15:0]};
   assign legal    = is_alu | is_j | is_jal | is_jr | is_jalr | is_br | is_lw | is_sw;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      is_alu  = 1'b0;
      is_j    = 1'b0;
      is_jal  = 1'b0;
      is_jr   = 1'b0;
      is_jalr = 1'b0;
      is_br   = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: is_alu = 1'b1;
               6'h08:   is_jr   = 1'b1;
               6'h09:   is_jalr = 1'b1;
               default: ;
            endcase
         end
         OP_J:    is_j   = 1'b1;
         OP_JAL:  is_jal = 1'b1;
         OP_BEQ:  is_br  = 1'b1;
`ifdef MC_CPU_BRANCH_EXT_EN
         OP_BNE, OP_BLEZ, OP_BGTZ: is_br = 1'b1;
         OP_REGIMM: is_br = (rt == 5'd0);
`endif
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: is_alu = 1'b1;
         OP_LW:   is_lw  = 1'b1;
         OP_SW:   is_sw  = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      br_taken = 1'b0;
      case (opcode)
         OP_BEQ:    br_taken = (a_reg == b_reg);
`ifdef MC_CPU_BRANCH_EXT_EN
         OP_BNE:    br_taken = (a_reg != b_reg);
         OP_BLEZ:   br_taken = a_reg[31] | (a_reg == 32'd0);
         OP_BGTZ:   br_taken = ~a_reg[31] & (a_reg != 32'd0);
         OP_REGIMM: br_taken = a_reg[31];
`endif
         default:   br_taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_res = 32'd0;
      if (opcode == OP_RTYPE) begin
         case (funct)
            6'h00:        alu_res = b_reg << shamt;
            6'h02:        alu_res = b_reg >> shamt;
            6'h03:        alu_res = $unsigned($signed(b_reg) >>> shamt);
            6'h20, 6'h21: alu_res = a_reg + b_reg;
            6'h22, 6'h23: alu_res = a_reg - b_reg;
            6'h24:        alu_res = a_reg & b_reg;
            6'h25:        alu_res = a_reg | b_reg;
            6'h26:        alu_res = a_reg ^ b_reg;
            6'h27:        alu_res = ~(a_reg | b_reg);
            6'h2a:        alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
            6'h2b:        alu_res = {31'd0, a_reg < b_reg};
            default:      alu_res = 32'd0;
         endcase
      end else begin
         case (opcode)
            OP_ADDI, OP_ADDIU: alu_res = a_reg + sext_imm;
            OP_SLTI:  alu_res = {31'd0, $signed(a_reg) < $signed(sext_imm)};
            OP_SLTIU: alu_res = {31'd0, a_reg < sext_imm};
            OP_ANDI:  alu_res = a_reg & zext_imm;
            OP_ORI:   alu_res = a_reg | zext_imm;
            OP_LUI:   alu_res = {ir[15:0], 16'h0000};
            default:  alu_res = 32'd0;
         endcase
      end
   end

   // Next state and memory port; the request is gated by reset so an abandoned access drops at once.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = reset;
            if (mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: state_nxt = (!legal || is_j || is_jal || is_jr || is_jalr) ? S_FETCH : S_EXEC;
         S_EXEC:   state_nxt = is_br ? S_FETCH : ((is_lw || is_sw) ? S_MEM : S_WB);
         S_MEM: begin
            mem_req = reset;
            if (mem_ready) state_nxt = is_lw ? S_WB : S_FETCH;
         end
         S_WB:     state_nxt = S_FETCH;
         default:  state_nxt = S_FETCH;
      endcase
   end

   assign mem_we    = (state == S_MEM) && is_sw;
   assign mem_addr  = (state == S_MEM) ? alu_out : pc;
   assign mem_wdata = b_reg;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (state == S_DECODE && is_jal) begin
         rf_we    = 1'b1;
         rf_waddr = 5'd31;
         rf_wdata = pc;
      end else if (state == S_DECODE && is_jalr) begin
         rf_we    = 1'b1;
         rf_waddr = rd;
         rf_wdata = pc;
      end else if (state == S_WB) begin
         rf_we    = 1'b1;
         rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
         rf_wdata = is_lw ? mdr : alu_out;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_nxt;
   end

   // NOTE: the register file is cleared on reset, so it is built from resettable flops, not a RAM macro.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (rf_we && rf_waddr != 5'd0) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_PC;
         ir      <= 32'd0;
         a_reg   <= 32'd0;
         b_reg   <= 32'd0;
         alu_out <= 32'd0;
         mdr     <= 32'd0;
      end else begin
         case (state)
            S_FETCH: if (mem_ready) begin
               ir <= mem_rdata;
               pc <= pc + 32'd4;
            end
            S_DECODE: begin
               a_reg   <= rf[rs];
               b_reg   <= rf[rt];
               alu_out <= pc + {sext_imm[29:0], 2'b00};
               if (is_j || is_jal)        pc <= {pc[31:28], ir[25:0], 2'b00};
               else if (is_jr || is_jalr) pc <= rf[rs];
            end
            S_EXEC: begin
               if (is_br) begin
                  if (br_taken) pc <= alu_out;
               end else if (is_lw || is_sw) begin
                  alu_out <= a_reg + sext_imm;
               end else begin
                  alu_out <= alu_res;
               end
            end
            S_MEM: if (mem_ready && is_lw) mdr <= mem_rdata;
            default: ;
         endcase
      end
   end

   assign output1 = rf[DBG_REG0];
   assign output2 = rf[DBG_REG1];

endmodule
